// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multicycle CPU: FSM states, opcodes,
// ALU source-B / ALU-op codes and the packed control-output bundle.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] SRCB_REG      = 3'b000;
    localparam logic [2:0] SRCB_FOUR     = 3'b001;
    localparam logic [2:0] SRCB_SEXT     = 3'b010;
    localparam logic [2:0] SRCB_SEXT_SH2 = 3'b011;
    localparam logic [2:0] SRCB_ZEXT     = 3'b100;
    localparam logic [2:0] SRCB_LUI      = 3'b101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_LUI);
    endfunction

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || is_itype(op);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational Moore output decoder: maps the current state (plus op and
// mem_ready where a state needs them) onto the full control bundle.
module mc_ctrl_outdec
    import cpu_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                // IR and PC only advance on the cycle the memory delivers
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b  = SRCB_SEXT_SH2;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.illegal_op = ~op_supported(i_op);
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_SEXT;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                case (i_op)
                    OP_SLTI: begin o_ctrl.alu_src_b = SRCB_SEXT; o_ctrl.alu_op = ALU_SLT; end
                    OP_ANDI: begin o_ctrl.alu_src_b = SRCB_ZEXT; o_ctrl.alu_op = ALU_AND; end
                    OP_ORI:  begin o_ctrl.alu_src_b = SRCB_ZEXT; o_ctrl.alu_op = ALU_OR;  end
                    OP_LUI:  begin o_ctrl.alu_src_b = SRCB_LUI;  o_ctrl.alu_op = ALU_ADD; end
                    default: begin o_ctrl.alu_src_b = SRCB_SEXT; o_ctrl.alu_op = ALU_ADD; end
                endcase
            end
            S_I_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REG;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.branch_ne     = (i_op == OP_BNE);
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU main controller: state register, started flop and
// next-state logic; outputs come from mc_ctrl_outdec, blanked until started.
module mc_ctrl_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       illegal_op
);

    state_t r_state;
    state_t w_state_next;
    logic   r_started;
    ctrl_t  w_ctrl;
    ctrl_t  w_ctrl_out;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_state_next = S_DECODE;
            S_DECODE: begin
                if (op == OP_RTYPE)                    w_state_next = S_R_EXEC;
                else if (op == OP_LW || op == OP_SW)   w_state_next = S_MEM_ADDR;
                else if (op == OP_BEQ || op == OP_BNE) w_state_next = S_BRANCH;
                else if (op == OP_J)                   w_state_next = S_JUMP;
                else if (is_itype(op))                 w_state_next = S_I_EXEC;
                else                                   w_state_next = S_FETCH;
            end
            S_MEM_ADDR: w_state_next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_state_next = S_MEM_WB;
            S_MEM_WB:   w_state_next = S_FETCH;
            S_MEM_WR:   if (mem_ready) w_state_next = S_FETCH;
            S_R_EXEC:   w_state_next = S_R_WB;
            S_R_WB:     w_state_next = S_FETCH;
            S_I_EXEC:   w_state_next = S_I_WB;
            S_I_WB:     w_state_next = S_FETCH;
            S_BRANCH:   w_state_next = S_FETCH;
            S_JUMP:     w_state_next = S_FETCH;
            default:    w_state_next = S_FETCH;
        endcase
    end

    // The first edge after release only arms the controller, so FETCH is
    // visible for a full cycle before any memory handshake can advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_started <= 1'b0;
        end else if (!r_started) begin
            r_started <= 1'b1;
        end else begin
            r_state   <= w_state_next;
        end
    end

    mc_ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_op        (op),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign w_ctrl_out    = r_started ? w_ctrl : '0;

    assign pc_write      = w_ctrl_out.pc_write;
    assign pc_write_cond = w_ctrl_out.pc_write_cond;
    assign branch_ne     = w_ctrl_out.branch_ne;
    assign pc_source     = w_ctrl_out.pc_source;
    assign iord          = w_ctrl_out.iord;
    assign mem_read      = w_ctrl_out.mem_read;
    assign mem_write     = w_ctrl_out.mem_write;
    assign ir_write      = w_ctrl_out.ir_write;
    assign reg_dst       = w_ctrl_out.reg_dst;
    assign mem_to_reg    = w_ctrl_out.mem_to_reg;
    assign reg_write     = w_ctrl_out.reg_write;
    assign alu_src_a     = w_ctrl_out.alu_src_a;
    assign alu_src_b     = w_ctrl_out.alu_src_b;
    assign alu_op        = w_ctrl_out.alu_op;
    assign illegal_op    = w_ctrl_out.illegal_op;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Table-driven bench for mc_ctrl_fsm: one vector per clock cycle with
// hand-written expected control words, plus reset sequences.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_source;
    logic [2:0] alu_src_b, alu_op;
    logic [19:0] w_act;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .illegal_op(illegal_op)
    );

    assign w_act = {pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read,
                    mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                    alu_src_b, alu_op, illegal_op};

    function automatic logic [19:0] mk(
        input logic a_pcw, input logic a_pcwc, input logic a_bne, input logic [1:0] a_psrc,
        input logic a_iord, input logic a_mr, input logic a_mw, input logic a_irw,
        input logic a_rd, input logic a_m2r, input logic a_rw, input logic a_asa,
        input logic [2:0] a_asb, input logic [2:0] a_aop, input logic a_ill);
        return {a_pcw, a_pcwc, a_bne, a_psrc, a_iord, a_mr, a_mw, a_irw,
                a_rd, a_m2r, a_rw, a_asa, a_asb, a_aop, a_ill};
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        n_checks++;
        if (w_act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b", name, w_act, exp);
        end else begin
            $display("ok   %s: %b", name, w_act);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic r, input logic [19:0] e);
        vec_t v;
        v.op = o; v.rdy = r; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        //                pcw pcwc bne psrc  iord mr mw irw rd m2r rw asa asb     aop     ill
        logic [19:0] E_Z, E_F1, E_F0, E_DEC, E_DILL, E_MADDR, E_MRD, E_MWB, E_MWR;
        logic [19:0] E_REX, E_RWB, E_ADDI, E_SLTI, E_ANDI, E_ORI, E_LUI, E_IWB;
        logic [19:0] E_BEQ, E_BNE, E_JMP;
        E_Z     = '0;
        E_F1    = mk(1, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 3'b001, 3'b000, 0);
        E_F0    = mk(0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000, 0);
        E_DEC   = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 3'b011, 3'b000, 0);
        E_DILL  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 3'b011, 3'b000, 1);
        E_MADDR = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 3'b010, 3'b000, 0);
        E_MRD   = mk(0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
        E_MWB   = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 3'b000, 3'b000, 0);
        E_MWR   = mk(0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
        E_REX   = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 3'b010, 0);
        E_RWB   = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 3'b000, 3'b000, 0);
        E_ADDI  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 3'b010, 3'b000, 0);
        E_SLTI  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 3'b010, 3'b101, 0);
        E_ANDI  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 3'b100, 3'b011, 0);
        E_ORI   = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 3'b100, 3'b100, 0);
        E_LUI   = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 3'b101, 3'b000, 0);
        E_IWB   = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 3'b000, 0);
        E_BEQ   = mk(0, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 3'b001, 0);
        E_BNE   = mk(0, 1, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 3'b001, 0);
        E_JMP   = mk(1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);

        // lw, zero wait
        add(6'b100011, 1, E_F1); add(6'b100011, 1, E_DEC); add(6'b100011, 1, E_MADDR);
        add(6'b100011, 1, E_MRD); add(6'b100011, 1, E_MWB);
        // sw, two wait cycles in MEM_WR
        add(6'b101011, 1, E_F1); add(6'b101011, 1, E_DEC); add(6'b101011, 1, E_MADDR);
        add(6'b101011, 0, E_MWR); add(6'b101011, 0, E_MWR); add(6'b101011, 1, E_MWR);
        // R-type
        add(6'b000000, 1, E_F1); add(6'b000000, 1, E_DEC); add(6'b000000, 1, E_REX);
        add(6'b000000, 1, E_RWB);
        // beq with one fetch wait, then bne
        add(6'b000100, 0, E_F0); add(6'b000100, 1, E_F1); add(6'b000100, 1, E_DEC);
        add(6'b000100, 1, E_BEQ);
        add(6'b000101, 1, E_F1); add(6'b000101, 1, E_DEC); add(6'b000101, 1, E_BNE);
        // I-type group
        add(6'b001100, 1, E_F1); add(6'b001100, 1, E_DEC); add(6'b001100, 1, E_ANDI);
        add(6'b001100, 1, E_IWB);
        add(6'b001111, 1, E_F1); add(6'b001111, 1, E_DEC); add(6'b001111, 1, E_LUI);
        add(6'b001111, 1, E_IWB);
        add(6'b001000, 1, E_F1); add(6'b001000, 1, E_DEC); add(6'b001000, 1, E_ADDI);
        add(6'b001000, 1, E_IWB);
        add(6'b001010, 1, E_F1); add(6'b001010, 1, E_DEC); add(6'b001010, 1, E_SLTI);
        add(6'b001010, 1, E_IWB);
        add(6'b001101, 1, E_F1); add(6'b001101, 1, E_DEC); add(6'b001101, 1, E_ORI);
        add(6'b001101, 1, E_IWB);
        // jump
        add(6'b000010, 1, E_F1); add(6'b000010, 1, E_DEC); add(6'b000010, 1, E_JMP);
        // illegal opcode, then lw with a read wait
        add(6'b111111, 1, E_F1); add(6'b111111, 1, E_DILL);
        add(6'b100011, 1, E_F1); add(6'b100011, 1, E_DEC); add(6'b100011, 1, E_MADDR);
        add(6'b100011, 0, E_MRD); add(6'b100011, 1, E_MRD); add(6'b100011, 1, E_MWB);

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_cycle%0d", i), E_Z);
        end
        rst_n = 1'b1;
        op = 6'b100011;
        mem_ready = 1'b1;
        #1 check("released_not_started", E_Z);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            op = vecs[i].op;
            mem_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d_op%b_rdy%0d", i, vecs[i].op, vecs[i].rdy), vecs[i].exp);
        end

        // asynchronous reset during MEM_WB must kill reg_write immediately
        #2 rst_n = 1'b0;
        #1 check("async_reset_in_mem_wb", E_Z);
        @(posedge clk);
        #1 check("reset_held_over_edge", E_Z);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1 check("restart_fetch_wait", E_F0);
        mem_ready = 1'b1;
        #1 check("restart_fetch_ready", E_F1);
        @(posedge clk);
        #1 check("restart_decode", E_DEC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
